// File: rtl/param_fifo_pkg.sv
// -----------------------------------------------------------------------------
// param_fifo_pkg
// Shared constants and helpers for the param_atlantic_fifo block.
//   clog2()       : ceiling log2, used for pointer widths.
//   fill_width()  : width of the fill-level counter, which must hold 0..DEPTH.
//   DEFAULT_*     : width constants for the default DEPTH of 8.
// -----------------------------------------------------------------------------
package param_fifo_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // The fill counter needs one more bit than the address so that DEPTH
  // itself (full) is representable.
  function automatic int fill_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_FILL_W = fill_width(DEFAULT_DEPTH);

endpackage

// File: rtl/param_atlantic_fifo_ram.sv
// -----------------------------------------------------------------------------
// param_atlantic_fifo_ram
// Simple dual-port storage: one synchronous write port and one registered
// read port, written so synthesis maps it onto block RAM.
// Ports:
//   clk      : clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write payload
//   rd_en    : read strobe; rd_data updates only on an enabled edge
//   rd_addr  : read address
//   rd_data  : registered read payload (old data on read/write collision)
// -----------------------------------------------------------------------------
module param_atlantic_fifo_ram
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 69,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port; no reset so the array stays mappable to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holding on !rd_en keeps the consumer's word stable.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/param_atlantic_fifo.sv
// -----------------------------------------------------------------------------
// param_atlantic_fifo
// Synchronous show-ahead FIFO with ready/valid handshakes on both sides.
// Optional feature: define PARAM_ATLANTIC_FIFO_FLUSH_EN to add a 'flush' input
// that empties the FIFO (pointers, level, flags, out_valid) but keeps the
// sticky overflow flag; flush wins over a same-cycle write or read.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   flush          : (PARAM_ATLANTIC_FIFO_FLUSH_EN only) synchronous empty
//   in_valid/in_ready/in_data    : write side, accepted when both high
//   out_valid/out_ready/out_data : read side, consumed when both high
//   fill_level     : number of entries held, 0..DEPTH
//   almost_full    : registered, fill_level >= AF_THRESH
//   almost_empty   : registered, fill_level <= AE_THRESH
//   overflow       : sticky, set when in_valid arrives while in_ready is low
// -----------------------------------------------------------------------------
module param_atlantic_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 69,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef PARAM_ATLANTIC_FIFO_FLUSH_EN
  input  logic                          flush,
`endif
  output logic                          in_ready,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [fill_width(DEPTH)-1:0]  fill_level,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int FW = fill_width(DEPTH);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
  localparam logic [FW-1:0] AF_LVL   = FW'(AF_THRESH);
  localparam logic [FW-1:0] AE_LVL   = FW'(AE_THRESH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  out_valid_q, out_valid_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [FW-1:0]         avail;
  logic                  wr_acc, rd_acc, load, bypass;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready = (fill_q != FULL_LVL);

  // Next-state logic. 'avail' counts words sitting in RAM that have not yet
  // been moved into the output register. A word is loaded from RAM when the
  // output register is empty or being consumed. The one case RAM cannot
  // cover is a write+read at level 1: the new word is still being written,
  // so it is captured straight into a bypass register to avoid a bubble.
  always_comb begin
    wr_acc      = in_valid && in_ready;
    rd_acc      = out_valid_q && out_ready;
    avail       = fill_q - FW'(out_valid_q);
    load        = (avail != '0) && (!out_valid_q || rd_acc);
    bypass      = wr_acc && rd_acc && (fill_q == FW'(1));

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    byp_sel_d   = byp_sel_q;
    byp_data_d  = byp_data_q;
    ovf_d       = ovf_q || (in_valid && !in_ready);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    // A bypassed word is also written to RAM, so the read pointer skips it.
    if (load || bypass) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    out_valid_d = load || bypass || (out_valid_q && !rd_acc);
    if (bypass) begin
      byp_sel_d  = 1'b1;
      byp_data_d = in_data;
    end else if (load) begin
      byp_sel_d  = 1'b0;
    end

`ifdef PARAM_ATLANTIC_FIFO_FLUSH_EN
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
      byp_sel_d   = 1'b0;
    end
`endif

    af_d = (fill_d >= AF_LVL);
    ae_d = (fill_d <= AE_LVL);
  end

  // Control state with synchronous reset; the empty FIFO is almost empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      ovf_q       <= 1'b0;
      byp_sel_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      ovf_q       <= ovf_d;
      byp_sel_q   <= byp_sel_d;
    end
  end

  // Payload-only register, deliberately left out of reset.
  always_ff @(posedge clk) begin
    byp_data_q <= byp_data_d;
  end

  param_atlantic_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (load),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  assign out_data     = byp_sel_q ? byp_data_q : ram_rd_data;
  assign out_valid    = out_valid_q;
  assign fill_level   = fill_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_param_atlantic_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_atlantic_fifo
// Directed bench for param_atlantic_fifo (DEPTH=8, DATA_WIDTH=69,
// AF_THRESH=6, AE_THRESH=2) followed by a scoreboarded random traffic phase.
// The flush scenario is built only with PARAM_ATLANTIC_FIFO_FLUSH_EN.
// -----------------------------------------------------------------------------
module tb_param_atlantic_fifo;

  localparam int DW = 69;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
`ifdef PARAM_ATLANTIC_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif
  logic          in_ready;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    fill_level;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;

  int testsRun  = 0;
  int failCount = 0;
  logic [DW-1:0] scoreboard [$];

  always #5 clk = ~clk;

  param_atlantic_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (8),
    .AF_THRESH  (6),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef PARAM_ATLANTIC_FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .in_ready     (in_ready),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .fill_level   (fill_level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow)
  );

  // Distinctive payload for directed word number i.
  function automatic logic [DW-1:0] mkw(input int i);
    logic [31:0] v;
    v = i;
    return {5'h15, 32'hDEAD_0000 ^ v, v};
  endfunction

  // Drive one cycle of inputs, clock it, and settle 1 time unit after the edge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic          doWr;
    logic          doRd;
    logic [DW-1:0] rnd;

    // Reset state.
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_fill", 128'(fill_level), 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_almost_empty", 128'(almost_empty), 128'(1));
    checkOutput("rst_almost_full", 128'(almost_full), 128'(0));
    checkOutput("rst_overflow", 128'(overflow), 128'(0));

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, mkw(i), 1'b0);
      checkOutput($sformatf("fill_level_%0d", i), 128'(fill_level), 128'(i + 1));
      checkOutput($sformatf("fill_af_%0d", i), 128'(almost_full), 128'((i + 1) >= 6));
      checkOutput($sformatf("fill_ae_%0d", i), 128'(almost_empty), 128'((i + 1) <= 2));
      checkOutput($sformatf("fill_in_ready_%0d", i), 128'(in_ready), 128'((i + 1) < 8));
      checkOutput($sformatf("fill_out_valid_%0d", i), 128'(out_valid), 128'(i >= 1));
      if (i >= 1) checkOutput($sformatf("fill_head_%0d", i), 128'(out_data), 128'(mkw(0)));
    end

    // Overflow attempt on a full FIFO.
    applyStimulus(1'b1, mkw(99), 1'b0);
    checkOutput("ovf_set", 128'(overflow), 128'(1));
    checkOutput("ovf_fill", 128'(fill_level), 128'(8));
    checkOutput("ovf_in_ready", 128'(in_ready), 128'(0));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("ovf_sticky", 128'(overflow), 128'(1));

    // Drain: the original eight words in order, nothing from the overflow attempt.
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain_valid_%0d", k), 128'(out_valid), 128'(1));
      checkOutput($sformatf("drain_data_%0d", k), 128'(out_data), 128'(mkw(k)));
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("drain_fill_%0d", k), 128'(fill_level), 128'(7 - k));
      checkOutput($sformatf("drain_ae_%0d", k), 128'(almost_empty), 128'((7 - k) <= 2));
      checkOutput($sformatf("drain_af_%0d", k), 128'(almost_full), 128'((7 - k) >= 6));
      checkOutput($sformatf("drain_out_valid_%0d", k), 128'(out_valid), 128'(k < 7));
    end
    checkOutput("drain_ovf_held", 128'(overflow), 128'(1));

    // Simultaneous write and read at fill_level 1.
    applyStimulus(1'b1, mkw(20), 1'b0);
    checkOutput("sim_first_latency", 128'(out_valid), 128'(0));
    checkOutput("sim_first_fill", 128'(fill_level), 128'(1));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("sim_first_valid", 128'(out_valid), 128'(1));
    checkOutput("sim_first_data", 128'(out_data), 128'(mkw(20)));
    for (int j = 21; j <= 22; j++) begin
      applyStimulus(1'b1, mkw(j), 1'b1);
      checkOutput($sformatf("sim_fill_%0d", j), 128'(fill_level), 128'(1));
      checkOutput($sformatf("sim_valid_%0d", j), 128'(out_valid), 128'(1));
      checkOutput($sformatf("sim_data_%0d", j), 128'(out_data), 128'(mkw(j)));
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("sim_end_fill", 128'(fill_level), 128'(0));
    checkOutput("sim_end_valid", 128'(out_valid), 128'(0));

    // Mid-stream reset at fill_level 5.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mkw(30 + i), 1'b0);
    checkOutput("mid_fill5", 128'(fill_level), 128'(5));
    checkOutput("mid_ovf_before", 128'(overflow), 128'(1));
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    reset = 1'b0;
    checkOutput("mid_fill", 128'(fill_level), 128'(0));
    checkOutput("mid_out_valid", 128'(out_valid), 128'(0));
    checkOutput("mid_in_ready", 128'(in_ready), 128'(1));
    checkOutput("mid_overflow", 128'(overflow), 128'(0));
    checkOutput("mid_ae", 128'(almost_empty), 128'(1));
    applyStimulus(1'b1, mkw(40), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("mid_post_valid", 128'(out_valid), 128'(1));
    checkOutput("mid_post_data", 128'(out_data), 128'(mkw(40)));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_post_empty", 128'(out_valid), 128'(0));

`ifdef PARAM_ATLANTIC_FIFO_FLUSH_EN
    // Flush at fill_level 4 with overflow already set.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, mkw(50 + i), 1'b0);
    applyStimulus(1'b1, mkw(98), 1'b0);
    checkOutput("fl_ovf_set", 128'(overflow), 128'(1));
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("fl_data_%0d", k), 128'(out_data), 128'(mkw(50 + k)));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("fl_fill4", 128'(fill_level), 128'(4));
    flush = 1'b1;
    applyStimulus(1'b1, mkw(97), 1'b1);
    flush = 1'b0;
    checkOutput("fl_fill", 128'(fill_level), 128'(0));
    checkOutput("fl_out_valid", 128'(out_valid), 128'(0));
    checkOutput("fl_in_ready", 128'(in_ready), 128'(1));
    checkOutput("fl_overflow_kept", 128'(overflow), 128'(1));
    checkOutput("fl_ae", 128'(almost_empty), 128'(1));
    checkOutput("fl_af", 128'(almost_full), 128'(0));
    applyStimulus(1'b1, mkw(61), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("fl_post_data", 128'(out_data), 128'(mkw(61)));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fl_post_empty", 128'(fill_level), 128'(0));
`endif

    // Random traffic against a queue scoreboard.
    scoreboard.delete();
    for (int c = 0; c < 200; c++) begin
      rnd = {5'($urandom), 32'($urandom), 32'($urandom)};
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checkOutput($sformatf("rnd_in_ready_%0d", c), 128'(in_ready), 128'(scoreboard.size() < 8));
      doWr = in_valid && in_ready;
      doRd = out_valid && out_ready;
      if (doRd) begin
        if (scoreboard.size() > 0) begin
          checkOutput($sformatf("rnd_data_%0d", c), 128'(out_data), 128'(scoreboard[0]));
          void'(scoreboard.pop_front());
        end else begin
          checkOutput($sformatf("rnd_spurious_valid_%0d", c), 128'(out_valid), 128'(0));
        end
      end
      if (doWr) scoreboard.push_back(rnd);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rnd_fill_%0d", c), 128'(fill_level), 128'(scoreboard.size()));
    end

    // Bounded drain of whatever the random phase left behind.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && scoreboard.size() > 0; k++) begin
      if (out_valid) begin
        checkOutput($sformatf("tail_data_%0d", k), 128'(out_data), 128'(scoreboard[0]));
        void'(scoreboard.pop_front());
      end
      @(posedge clk);
      #1;
    end
    checkOutput("tail_left", 128'(scoreboard.size()), 128'(0));
    checkOutput("tail_fill", 128'(fill_level), 128'(0));
    checkOutput("tail_out_valid", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/param_atlantic_fifo.md
PARAM_ATLANTIC_FIFO -- requirements
Module: param_atlantic_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 69, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, at least 4.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty threshold in entries.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port in_ready, output, 1 bit, sink ready.
REQ-008 SHALL have port in_valid, input, 1 bit, source valid.
REQ-009 SHALL have port in_data, input, DATA_WIDTH bits, write payload.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream ready.
REQ-011 SHALL have port out_valid, output, 1 bit, output word valid.
REQ-012 SHALL have port out_data, output, DATA_WIDTH bits, registered read payload.
REQ-013 SHALL have port fill_level, output, clog2(DEPTH)+1 bits, entries held, 0..DEPTH.
REQ-014 SHALL have port almost_full, output, 1 bit, high when fill_level >= AF_THRESH.
REQ-015 SHALL have port almost_empty, output, 1 bit, high when fill_level <= AE_THRESH.
REQ-016 SHALL have port overflow, output, 1 bit, sticky flag set by in_valid while in_ready is low.

Function
REQ-017 SHALL accept a write on a rising edge when in_valid and in_ready are both high.
REQ-018 SHALL complete a read on a rising edge when out_valid and out_ready are both high.
REQ-019 SHALL drive in_ready as !full, combinational from state only, with no same-cycle dependence on out_ready.
REQ-020 SHALL raise out_valid and present the word one cycle after the edge that accepted the first write into an empty FIFO.
REQ-021 SHALL present words in write order.
REQ-022 SHALL present the next word on the edge after a read with no bubble while fill_level > 1 (read-ahead address).
REQ-023 SHALL increment fill_level by 1 on write only, decrement by 1 on read only, and hold it on simultaneous write and read.
REQ-024 SHALL wrap the write and read pointers modulo DEPTH; full is fill_level==DEPTH and empty is fill_level==0.
REQ-025 SHALL, on a simultaneous write and read with fill_level==1, keep out_valid high and show the new word on the next edge.
REQ-026 SHALL drop out_valid on the edge of the read that empties the FIFO.
REQ-027 SHALL update almost_full and almost_empty as registered outputs, consistent with fill_level in the same cycle.
REQ-028 SHALL keep out_data stable while out_valid is high and out_ready is low.

Reset
REQ-029 SHALL, on reset high at a clock edge, clear both pointers, and drive fill_level=0, out_valid=0, in_ready=1, almost_empty=1, almost_full=0, overflow=0.
REQ-030 SHALL discard all contents on a mid-operation reset; memory contents are don't-care and out_data is not reset.

Configuration
REQ-031 SHALL, with macro PARAM_ATLANTIC_FIFO_FLUSH_EN defined, add a 1-bit input flush that acts as reset on pointers, flags and out_valid without clearing overflow, and takes priority over a same-cycle write or read.
REQ-032 SHALL, without PARAM_ATLANTIC_FIFO_FLUSH_EN, have no flush port and no flush logic.

Structure
REQ-033 SHALL place the clog2 function and the fill-level width constant in package param_fifo_pkg.
REQ-034 SHALL implement storage in sub-module param_atlantic_fifo_ram: one write port, one registered read port, inferring block RAM.

Verification
REQ-035 SHALL cover fill-to-full: DEPTH=8, 8 writes with out_ready=0 -> in_ready=0 after the 8th edge, fill_level=8, almost_full=1 from the 6th write.
REQ-036 SHALL cover drain: full FIFO, out_ready=1 for 8 cycles -> data 0..7 in order, out_valid=0 after the 8th read, almost_empty=1 from fill_level=2.
REQ-037 SHALL cover simultaneous write and read at fill_level=1 -> fill_level stays 1, out_valid never drops.
REQ-038 SHALL cover overflow: full FIFO, in_valid=1 for one cycle -> overflow=1 held until reset, contents unchanged.
REQ-039 SHALL cover mid-stream reset: reset at fill_level=5 -> next cycle fill_level=0, out_valid=0, in_ready=1.
REQ-040 SHALL cover flush (PARAM_ATLANTIC_FIFO_FLUSH_EN) plus random traffic: flush at fill_level=4 -> empty the next cycle with overflow kept; then 200 random in_valid/out_ready cycles -> scoreboard shows no loss or reordering.
